hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Parametrised pipeline hazard and stall controller for the five-stage MIPS core. It replaces the single-bubble load-use detector. It adds:
- configurable register-address width,
- r0 and operand-usage qualification,
- taken-branch flush of IF/ID,
- a sequential freeze of the whole pipeline while a data-memory access waits for acknowledge, with a timeout guard.

It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their enables and the PC enable.

## Interface
Parameters:
- REG_AW, 5: register address width.
- MEM_TO, 64: maximum cycles to wait for dmem_ack before a forced release. Must be 2 or more.
- CNT_W, 16: width of the wait counter and the performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ifidrs  input  REG_AW  rs field of the instruction in IF/ID.
- ifidrt  input  REG_AW  rt field of the instruction in IF/ID.
- ifid_use_rs  input  1  the IF/ID instruction reads rs.
- ifid_use_rt  input  1  the IF/ID instruction reads rt.
- idexrt  input  REG_AW  destination rt of the instruction in ID/EX.
- idexmemrd  input  1  the ID/EX instruction is a load.
- branch_taken  input  1  a branch resolved taken in EX this cycle.
- exmem_memop  input  1  the EX/MEM instruction accesses data memory.
- dmem_ack  input  1  data memory completes the access this cycle.
- pcen  output  1  PC write enable.
- ifiden  output  1  IF/ID write enable.
- ifidflush  output  1  load NOP into IF/ID.
- ctrlsig  output  1  select NOP control signals into ID/EX (bubble).
- idexen  output  1  ID/EX write enable.
- exmemen  output  1  EX/MEM write enable.
- mem_err  output  1  one-cycle pulse on memory timeout.
- stall_cnt  output  CNT_W  load-use bubbles inserted.
- flush_cnt  output  CNT_W  IF/ID flushes.
- memwait_cnt  output  CNT_W  frozen cycles.

## Operation
- State: RUN or MEMWAIT, plus wait counter wcnt (CNT_W bits).

Combinational terms:
- lu = idexmemrd & (idexrt != 0) & ((ifid_use_rs & ifidrs == idexrt) | (ifid_use_rt & ifidrt == idexrt)).
- hit = (state == MEMWAIT) & (wcnt == MEM_TO-1).
- freeze = exmem_memop & ~dmem_ack & ~hit.

Output priority, highest first:
- **freeze:** pcen = ifiden = idexen = exmemen = 0; ctrlsig = 0; ifidflush = 0. A branch_taken asserted during freeze re-presents after release and is honoured then.
- **branch_taken:** ifidflush = 1; pcen = 1; ctrlsig = 0. lu is ignored because the dependent instruction is squashed.
- **lu:** pcen = 0; ifiden = 0; ctrlsig = 1; idexen = 1; exmemen = 1.
- **Otherwise:** all enables 1; ctrlsig = 0; ifidflush = 0.

Transitions:
- RUN to MEMWAIT when freeze; wcnt is set to 1.
- MEMWAIT to RUN when dmem_ack, or when hit.
- Otherwise MEMWAIT holds and wcnt increments.

Timeout:
- In the hit cycle, freeze is forced low so the pipeline advances.
- mem_err is registered and is high for exactly the cycle after hit.

Register-number rules:
- Register 0 never causes a load-use hazard.
- Comparisons use the full REG_AW bits.

## Timing
- All hazard outputs are combinational from inputs and state, with zero-cycle latency.
- A load-use bubble lasts exactly one cycle. On the next cycle the load has moved to EX/MEM, so lu falls.
- A memory access acknowledged in its first MEM cycle causes no freeze.
- An access acknowledged after N waiting cycles freezes for exactly N cycles.
- The timeout releases after MEM_TO-1 frozen cycles. mem_err is high in the next cycle.
- The state machine is back in RUN in the cycle after release.
- If freeze and a new access arrive back-to-back, RUN to MEMWAIT occurs again with no idle cycle.
- Reset values: state RUN, wcnt 0, mem_err 0, all counters 0.
- rst_n asserted mid-wait returns to RUN immediately and asynchronously. The outputs then follow the RUN equations.

## Configuration
- HAZARD_PERF_CNT_EN
  - **Defined:** stall_cnt increments on each cycle with lu active and not overridden. flush_cnt increments on each ifidflush cycle. memwait_cnt increments on each freeze cycle. All three saturate at 2^CNT_W-1 and clear only on reset.
  - **Undefined:** the three ports exist but are tied to 0, and no counter flops are built.

## Structure
- Package hazard_pkg holds:
  - the state enum (HZ_RUN, HZ_MEMWAIT),
  - the default REG_AW, CNT_W and MEM_TO constants,
  - a localparam for the register-0 encoding.
- One sub-module, hazard_sat_counter (CNT_W, inc, clk, rst_n, q), is instantiated three times under HAZARD_PERF_CNT_EN.

## Test plan
- **Load-use on rs:** idexmemrd=1, idexrt=5, ifidrs=5, use_rs=1 -> pcen=0, ifiden=0, ctrlsig=1 for one cycle. The next cycle has all enables 1. stall_cnt=1.
- **r0 and unused operand:** idexrt=0 with ifidrs=0, or idexrt=7 with ifidrt=7 and use_rt=0 -> no stall; pcen=1, ctrlsig=0.
- **Branch overrides load-use:** lu active and branch_taken=1 in the same cycle -> ifidflush=1, ctrlsig=0, pcen=1. flush_cnt=1, stall_cnt=0.
- **Memory wait:** exmem_memop=1 with dmem_ack arriving 3 cycles later -> exactly 3 cycles with all enables 0, then release. memwait_cnt=3. State returns to RUN.
- **Timeout:** MEM_TO=4, exmem_memop held 1, dmem_ack never asserted -> freeze for 3 cycles, release on the 4th, mem_err pulses high for 1 cycle, and a new wait starts if memop persists.
- **Reset mid-wait:** rst_n low during MEMWAIT -> immediate RUN, wcnt=0, counters 0, mem_err 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and defaults for the pipeline hazard / stall
//                controller: controller state encoding, parameter defaults
//                and the register-0 encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [0:0] {
    HZ_RUN     = 1'b0,
    HZ_MEMWAIT = 1'b1
  } hz_state_e;

  localparam int HZ_REG_AW_DEF = 5;
  localparam int HZ_MEM_TO_DEF = 64;
  localparam int HZ_CNT_W_DEF  = 16;

  // Architectural zero register; writes to it are discarded, so it never
  // carries a real dependency.
  localparam int HZ_R0 = 0;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl_if
//  Description : Bundle of hazard-detection inputs and pipeline-control
//                outputs exchanged between the pipeline and the controller.
//  Ports       : master -> drives the hazard inputs, receives enables/counters
//                slave  -> the controller side
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = hazard_pkg::HZ_REG_AW_DEF,
  parameter int CNT_W  = hazard_pkg::HZ_CNT_W_DEF
);
  logic [REG_AW-1:0] ifidrs;
  logic [REG_AW-1:0] ifidrt;
  logic              ifid_use_rs;
  logic              ifid_use_rt;
  logic [REG_AW-1:0] idexrt;
  logic              idexmemrd;
  logic              branch_taken;
  logic              exmem_memop;
  logic              dmem_ack;

  logic              pcen;
  logic              ifiden;
  logic              ifidflush;
  logic              ctrlsig;
  logic              idexen;
  logic              exmemen;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  memwait_cnt;

  modport master (
    output ifidrs, ifidrt, ifid_use_rs, ifid_use_rt, idexrt, idexmemrd,
           branch_taken, exmem_memop, dmem_ack,
    input  pcen, ifiden, ifidflush, ctrlsig, idexen, exmemen, mem_err,
           stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  ifidrs, ifidrt, ifid_use_rs, ifid_use_rt, idexrt, idexmemrd,
           branch_taken, exmem_memop, dmem_ack,
    output pcen, ifiden, ifidflush, ctrlsig, idexen, exmemen, mem_err,
           stall_cnt, flush_cnt, memwait_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sat_counter
//  Description : Saturating up-counter, cleared only by reset.
//  Ports       : clk, rst_n (async active-low), inc (count enable),
//                q (count, sticks at all-ones)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline hazard and stall controller. Detects load-use
//                hazards (r0 / operand-usage qualified), flushes IF/ID on a
//                taken branch and freezes the whole pipeline while a data
//                memory access waits for acknowledge, with a timeout release.
//  Ports       : clk, rst_n (async active-low)
//                bus (slave) : hazard inputs, pipeline enables, mem_err,
//                              performance counters
//  Config      : HAZARD_PERF_CNT_EN - builds the saturating performance
//                counters; otherwise the counter outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW_DEF,
  parameter int MEM_TO = HZ_MEM_TO_DEF,
  parameter int CNT_W  = HZ_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);

  hz_state_e        state_q;
  logic [CNT_W-1:0] wcnt_q;
  logic             mem_err_q;

  logic lu;
  logic hit;
  logic freeze;

  logic pcen_w, ifiden_w, ifidflush_w, ctrlsig_w, idexen_w, exmemen_w;

  localparam logic [REG_AW-1:0] R0_ENC   = REG_AW'(HZ_R0);
  localparam logic [CNT_W-1:0]  WCNT_HIT = CNT_W'(MEM_TO - 1);

  assign lu = bus.idexmemrd && (bus.idexrt != R0_ENC) &&
              ((bus.ifid_use_rs && (bus.ifidrs == bus.idexrt)) ||
               (bus.ifid_use_rt && (bus.ifidrt == bus.idexrt)));

  assign hit    = (state_q == HZ_MEMWAIT) && (wcnt_q == WCNT_HIT);
  // The hit cycle lets the pipeline advance even without an acknowledge.
  assign freeze = bus.exmem_memop && !bus.dmem_ack && !hit;

  always_comb begin
    pcen_w      = 1'b1;
    ifiden_w    = 1'b1;
    ifidflush_w = 1'b0;
    ctrlsig_w   = 1'b0;
    idexen_w    = 1'b1;
    exmemen_w   = 1'b1;
    if (freeze) begin
      // A taken branch seen here is held in EX and honoured after release.
      pcen_w    = 1'b0;
      ifiden_w  = 1'b0;
      idexen_w  = 1'b0;
      exmemen_w = 1'b0;
    end else if (bus.branch_taken) begin
      // The dependent instruction is squashed, so a load-use stall is moot.
      ifidflush_w = 1'b1;
    end else if (lu) begin
      pcen_w    = 1'b0;
      ifiden_w  = 1'b0;
      ctrlsig_w = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HZ_RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= hit;
      case (state_q)
        HZ_RUN: begin
          if (freeze) begin
            state_q <= HZ_MEMWAIT;
            wcnt_q  <= CNT_W'(1);
          end
        end
        HZ_MEMWAIT: begin
          if (bus.dmem_ack || hit) begin
            state_q <= HZ_RUN;
            wcnt_q  <= '0;
          end else begin
            wcnt_q  <= wcnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= HZ_RUN;
          wcnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.pcen      = pcen_w;
  assign bus.ifiden    = ifiden_w;
  assign bus.ifidflush = ifidflush_w;
  assign bus.ctrlsig   = ctrlsig_w;
  assign bus.idexen    = idexen_w;
  assign bus.exmemen   = exmemen_w;
  assign bus.mem_err   = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;
  // Only bubbles actually inserted count: freeze and branch override lu.
  assign stall_inc = lu && !freeze && !bus.branch_taken;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .q     (bus.stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifidflush_w),
    .q     (bus.flush_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze),
    .q     (bus.memwait_cnt)
  );
`else
  assign bus.stall_cnt   = '0;
  assign bus.flush_cnt   = '0;
  assign bus.memwait_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl. Directed cases
//                followed by random stimulus; expected outputs come from a
//                behavioural model and are queued for a negedge monitor.
//  Config      : honours HAZARD_PERF_CNT_EN for the counter expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int REG_AW = 5;
  localparam int MEM_TO = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              rstn;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] xrt;
    logic              urs;
    logic              urt;
    logic              mrd;
    logic              br;
    logic              memop;
    logic              ack;
  } in_t;

  typedef struct {
    logic pcen, ifiden, ifidflush, ctrlsig, idexen, exmemen, mem_err;
    int   stall, flush, memwait;
  } exp_t;

  logic clk;
  logic rst_n;

  hazard_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.REG_AW(REG_AW), .MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  in_t  cur;

  // Reference model: is a memory access outstanding, for how many cycles,
  // and the event totals.
  bit m_waiting;
  int m_waited;
  bit m_err;
  int m_stall, m_flush, m_memwait;

  function automatic void model_reset();
    m_waiting = 0; m_waited = 0; m_err = 0;
    m_stall = 0; m_flush = 0; m_memwait = 0;
  endfunction

  function automatic bit f_lu(input in_t s);
    return s.mrd && (s.xrt != 0) &&
           ((s.urs && s.rs == s.xrt) || (s.urt && s.rt == s.xrt));
  endfunction

  function automatic bit f_hit();
    return m_waiting && (m_waited == MEM_TO - 1);
  endfunction

  function automatic bit f_freeze(input in_t s);
    return s.memop && !s.ack && !f_hit();
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic exp_t model_out(input in_t s);
    exp_t e;
    bit frz;
    frz = f_freeze(s);
    e.pcen = 1; e.ifiden = 1; e.ifidflush = 0; e.ctrlsig = 0;
    e.idexen = 1; e.exmemen = 1;
    if (frz) begin
      e.pcen = 0; e.ifiden = 0; e.idexen = 0; e.exmemen = 0;
    end else if (s.br) begin
      e.ifidflush = 1;
    end else if (f_lu(s)) begin
      e.pcen = 0; e.ifiden = 0; e.ctrlsig = 1;
    end
    e.mem_err = m_err;
`ifdef HAZARD_PERF_CNT_EN
    e.stall = m_stall; e.flush = m_flush; e.memwait = m_memwait;
`else
    e.stall = 0; e.flush = 0; e.memwait = 0;
`endif
    return e;
  endfunction

  // Advance the model across one rising edge with the inputs held before it.
  function automatic void model_step(input in_t s);
    bit frz, hit;
    if (!s.rstn) begin
      model_reset();
      return;
    end
    frz = f_freeze(s);
    hit = f_hit();
    if (f_lu(s) && !frz && !s.br) m_stall = sat(m_stall + 1);
    if (!frz && s.br)             m_flush = sat(m_flush + 1);
    if (frz)                      m_memwait = sat(m_memwait + 1);
    m_err = hit;
    if (!m_waiting) begin
      if (frz) begin m_waiting = 1; m_waited = 1; end
    end else if (s.ack || hit) begin
      m_waiting = 0; m_waited = 0;
    end else begin
      m_waited++;
    end
  endfunction

  task automatic apply(input in_t s);
    rst_n                = s.rstn;
    bus.ifidrs           = s.rs;
    bus.ifidrt           = s.rt;
    bus.idexrt           = s.xrt;
    bus.ifid_use_rs      = s.urs;
    bus.ifid_use_rt      = s.urt;
    bus.idexmemrd        = s.mrd;
    bus.branch_taken     = s.br;
    bus.exmem_memop      = s.memop;
    bus.dmem_ack         = s.ack;
    cur                  = s;
  endtask

  // One cycle: edge updates the model, then new inputs and their expectation.
  task automatic step(input in_t s);
    @(posedge clk);
    model_step(cur);
    #1;
    apply(s);
    if (!s.rstn) model_reset();
    exp_q.push_back(model_out(s));
  endtask

  function automatic in_t idle();
    in_t s;
    s = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pcen",        32'(bus.pcen),        int'(e.pcen));
        chk("ifiden",      32'(bus.ifiden),      int'(e.ifiden));
        chk("ifidflush",   32'(bus.ifidflush),   int'(e.ifidflush));
        chk("ctrlsig",     32'(bus.ctrlsig),     int'(e.ctrlsig));
        chk("idexen",      32'(bus.idexen),      int'(e.idexen));
        chk("exmemen",     32'(bus.exmemen),     int'(e.exmemen));
        chk("mem_err",     32'(bus.mem_err),     int'(e.mem_err));
        chk("stall_cnt",   32'(bus.stall_cnt),   e.stall);
        chk("flush_cnt",   32'(bus.flush_cnt),   e.flush);
        chk("memwait_cnt", 32'(bus.memwait_cnt), e.memwait);
      end
    end
  end

  initial begin : driver
    in_t s;
    s = idle();
    s.rstn = 1'b0;
    apply(s);
    model_reset();
    step(s);                                   // reset state
    step(idle());

    // load-use on rs, then the load has moved on
    s = idle(); s.mrd = 1; s.xrt = 5; s.rs = 5; s.urs = 1;
    step(s);
    step(idle());
    // r0 never stalls; unused rt never stalls
    s = idle(); s.mrd = 1; s.xrt = 0; s.rs = 0; s.urs = 1; s.urt = 1;
    step(s);
    s = idle(); s.mrd = 1; s.xrt = 7; s.rt = 7; s.urt = 0;
    step(s);
    // load-use on rt
    s = idle(); s.mrd = 1; s.xrt = 31; s.rt = 31; s.urt = 1;
    step(s);
    // branch overrides load-use
    s = idle(); s.mrd = 1; s.xrt = 5; s.rs = 5; s.urs = 1; s.br = 1;
    step(s);
    step(idle());

    // memory wait, ack after 3 waiting cycles (branch pending during freeze)
    s = idle(); s.memop = 1; s.br = 1;
    repeat (3) step(s);
    s.ack = 1;
    step(s);
    step(idle());
    // ack in the first MEM cycle: no freeze
    s = idle(); s.memop = 1; s.ack = 1;
    step(s);
    // timeout with memop held, then a new wait starts immediately
    s = idle(); s.memop = 1;
    repeat (6) step(s);
    s.ack = 1;
    step(s);
    // back-to-back accesses
    s = idle(); s.memop = 1;
    step(s);
    s.ack = 1;
    step(s);
    s.ack = 0;
    step(s);
    s.ack = 1;
    step(s);
    step(idle());

    // reset mid-wait
    s = idle(); s.memop = 1;
    repeat (2) step(s);
    s.rstn = 0;
    step(s);
    step(s);
    step(idle());

    // random
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rstn  = ($urandom_range(0, 199) != 0);
      s.rs    = REG_AW'($urandom_range(0, 3));
      s.rt    = REG_AW'($urandom_range(0, 3));
      s.xrt   = REG_AW'($urandom_range(0, 3));
      s.urs   = 1'($urandom_range(0, 1));
      s.urt   = 1'($urandom_range(0, 1));
      s.mrd   = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 7) == 0);
      s.memop = ($urandom_range(0, 1) == 0);
      s.ack   = ($urandom_range(0, 2) == 0);
      step(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
